flag_update_unit: RTL and testbench

- Sits directly upstream of the 3-bit flag register in the register file.
- Converts EX-stage ALU flag results and the opcode into the flag register's per-bit data and write-enable lines, through one registered commit stage.
- Keeps a shadow copy of the committed flags.
- Resolves branch conditions combinationally from forwarded flags, for the branch logic in decode.

---
 rtl/flag_update_unit.sv | 144 ++++++++++++++
 tb/tb_flag_update_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_update_unit.sv
// Flag commit stage for the 3-bit {Z,V,N} flag register: one registered commit
// stage, a shadow copy of committed flags, and forwarded branch resolution.
module flag_update_unit #(
    parameter bit          FWD_EX = 1'b1,
    parameter int unsigned OPC_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [OPC_W-1:0] ex_opcode,
    input  logic [2:0]       alu_flags,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    output logic [2:0]       flag_d,
    output logic [2:0]       flag_we,
    output logic [2:0]       flags_cur,
    output logic             br_taken,
    output logic             halted
);

    localparam int unsigned FLG_W = 3;

    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h0);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h1);
    localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4'h2);
    localparam logic [OPC_W-1:0] OP_SLL = OPC_W'(4'h4);
    localparam logic [OPC_W-1:0] OP_SRA = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OP_ROR = OPC_W'(4'h6);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_halted;
    logic             w_halted_nxt;
    logic             w_capture;
    logic [FLG_W-1:0] w_mask;
    logic [FLG_W-1:0] r_flag_d;
    logic [FLG_W-1:0] r_flag_we;
    logic [FLG_W-1:0] r_shadow;
    logic [FLG_W-1:0] w_fwd_ex;
    logic [FLG_W-1:0] w_committed_view;
    logic [FLG_W-1:0] w_flags_cur;
    logic             w_z;
    logic             w_v;
    logic             w_n;
    logic             w_cond;

    // Which flags the EX opcode is allowed to update
    always_comb begin
        w_mask = '0;
        case (ex_opcode)
            OP_ADD, OP_SUB:                 w_mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_mask = 3'b100;
            default:                        w_mask = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // Next-state, capture qualification and registered-halt input
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_halted_nxt = 1'b0;
        case (r_state)
            S_RUN: begin
                w_capture = ex_valid & ~stall & ~flush;
                if (w_capture && (ex_opcode == OP_HLT)) begin
                    w_state_nxt  = S_HALTED;
                    w_halted_nxt = 1'b1;
                end
            end
            S_HALTED: begin
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Pending stage; a bubble clears the enables so flag_we is pend_valid-qualified
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flag_d  <= '0;
            r_flag_we <= '0;
            r_shadow  <= '0;
        end else begin
            r_shadow  <= (r_shadow & ~r_flag_we) | (r_flag_d & r_flag_we);
            r_flag_we <= w_capture ? w_mask : '0;
            if (w_capture) begin
                r_flag_d <= alu_flags;
            end
        end
    end

    // Forwarding priority: EX (optional), then pending commit, then shadow
    always_comb begin
        w_fwd_ex         = (FWD_EX && w_capture) ? w_mask : '0;
        w_committed_view = (r_flag_d & r_flag_we) | (r_shadow & ~r_flag_we);
        w_flags_cur      = (alu_flags & w_fwd_ex) | (w_committed_view & ~w_fwd_ex);
    end

    assign w_z = w_flags_cur[2];
    assign w_v = w_flags_cur[1];
    assign w_n = w_flags_cur[0];

    always_comb begin
        w_cond = 1'b0;
        case (br_cond)
            3'b000:  w_cond = ~w_z;
            3'b001:  w_cond = w_z;
            3'b010:  w_cond = ~w_z & ~w_n;
            3'b011:  w_cond = w_n;
            3'b100:  w_cond = w_z | (~w_z & ~w_n);
            3'b101:  w_cond = w_n | w_z;
            3'b110:  w_cond = w_v;
            default: w_cond = 1'b1;
        endcase
    end

    assign flag_d    = r_flag_d;
    assign flag_we   = r_flag_we;
    assign flags_cur = w_flags_cur;
    assign br_taken  = br_valid & w_cond;
    assign halted    = r_halted;

endmodule

// File: tb/tb_flag_update_unit.sv
// Bench for flag_update_unit: both forwarding variants side by side, directed
// scenarios followed by random traffic, checked against a behavioural model.
module tb_flag_update_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ex_valid = 1'b0;
    logic [3:0] ex_opcode = 4'h0;
    logic [2:0] alu_flags = 3'b000;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       br_valid = 1'b0;
    logic [2:0] br_cond = 3'b000;

    logic [2:0] fd1, fw1, fc1, fd0, fw0, fc0;
    logic       bt1, h1, bt0, h0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_pv, m_halt;
    logic [2:0] m_pd, m_pw, m_sh;

    // Combinational outputs sampled inside the last step
    logic [2:0] obs_we1;
    logic       obs_bt1, obs_bt0;

    always #5 clk = ~clk;

    flag_update_unit #(.FWD_EX(1'b1), .OPC_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .alu_flags(alu_flags), .stall(stall), .flush(flush),
        .br_valid(br_valid), .br_cond(br_cond),
        .flag_d(fd1), .flag_we(fw1), .flags_cur(fc1), .br_taken(bt1), .halted(h1)
    );

    flag_update_unit #(.FWD_EX(1'b0), .OPC_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .alu_flags(alu_flags), .stall(stall), .flush(flush),
        .br_valid(br_valid), .br_cond(br_cond),
        .flag_d(fd0), .flag_we(fw0), .flags_cur(fc0), .br_taken(bt0), .halted(h0)
    );

    function automatic logic [2:0] mask_of(input logic [3:0] op);
        case (op)
            4'd0, 4'd1:             return 3'b111;
            4'd2, 4'd4, 4'd5, 4'd6: return 3'b100;
            default:                return 3'b000;
        endcase
    endfunction

    function automatic logic cond_of(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] fwd_of(input bit use_ex, input bit cap, input logic [2:0] alu);
        logic [2:0] r;
        logic [2:0] mk;
        mk = mask_of(ex_opcode);
        for (int i = 0; i < 3; i++) begin
            if (use_ex && cap && mk[i])   r[i] = alu[i];
            else if (m_pv && m_pw[i])     r[i] = m_pd[i];
            else                          r[i] = m_sh[i];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pv = 1'b0; m_pd = 3'b000; m_pw = 3'b000; m_sh = 3'b000; m_halt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        ex_valid = 1'b0; stall = 1'b0; flush = 1'b0; br_valid = 1'b0;
        ex_opcode = 4'h0; alu_flags = 3'b000; br_cond = 3'b000;
        model_clear();
        #1;
        chk("rst_flag_we", fw1, 3'b000);
        chk("rst_flag_d", fd1, 3'b000);
        chk("rst_halted", 3'(h1), 3'b000);
        chk("rst_halted_nofwd", 3'(h0), 3'b000);
        chk("rst_flags_cur", fc1, 3'b000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: drive at negedge, check combinational and registered outputs, advance model
    task automatic step(input bit v, input logic [3:0] op, input logic [2:0] alu,
                        input bit st, input bit fl, input bit bv, input logic [2:0] bc);
        bit         cap;
        logic [2:0] exp_we, e_fc1, e_fc0;
        @(negedge clk);
        ex_valid = v; ex_opcode = op; alu_flags = alu;
        stall = st; flush = fl; br_valid = bv; br_cond = bc;
        #1;
        cap    = v && !st && !fl && !m_halt;
        exp_we = m_pv ? m_pw : 3'b000;
        e_fc1  = fwd_of(1'b1, cap, alu);
        e_fc0  = fwd_of(1'b0, cap, alu);
        obs_we1 = fw1; obs_bt1 = bt1; obs_bt0 = bt0;
        chk("flag_we", fw1, exp_we);
        chk("flag_we_nofwd", fw0, exp_we);
        chk("flag_d", fd1, m_pd);
        chk("flag_d_nofwd", fd0, m_pd);
        chk("flags_cur", fc1, e_fc1);
        chk("flags_cur_nofwd", fc0, e_fc0);
        chk("br_taken", 3'(bt1), 3'(bv && cond_of(bc, e_fc1)));
        chk("br_taken_nofwd", 3'(bt0), 3'(bv && cond_of(bc, e_fc0)));
        chk("halted", 3'(h1), 3'(m_halt));
        chk("halted_nofwd", 3'(h0), 3'(m_halt));
        @(posedge clk);
        m_sh = (m_sh & ~exp_we) | (m_pd & exp_we);
        if (cap) begin
            m_pv = 1'b1; m_pd = alu; m_pw = mask_of(op);
            if (op == 4'hF) m_halt = 1'b1;
        end else begin
            m_pv = 1'b0;
        end
    endtask

    task automatic idle();
        step(1'b0, 4'h3, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        model_clear();
        do_reset();

        // Reset then idle: EQ branch with Z=0 is not taken
        step(1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001);
        chk("idle_eq_branch", 3'(obs_bt1), 3'b000);

        // SUB commit with one cycle latency
        step(1'b1, 4'h1, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000);
        #1; chk("sub_we", fw1, 3'b111); chk("sub_d", fd1, 3'b101);
        idle();
        #1; chk("sub_we_after", fw1, 3'b000); chk("sub_shadow", fc1, 3'b101);

        // Partial update: shadow 011, XOR writes Z only
        step(1'b1, 4'h0, 3'b011, 1'b0, 1'b0, 1'b0, 3'b000);
        idle();
        step(1'b1, 4'h2, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000);
        #1; chk("xor_we", fw1, 3'b100); chk("xor_d", fd1, 3'b010);
        idle();
        #1; chk("xor_shadow", fc1, 3'b011);

        // Forwarding of same-cycle EX flags vs pending-stage forwarding
        step(1'b1, 4'h0, 3'b100, 1'b0, 1'b0, 1'b1, 3'b001);
        chk("fwd_ex_taken", 3'(obs_bt1), 3'b001);
        chk("fwd_noex_not_taken", 3'(obs_bt0), 3'b000);
        step(1'b0, 4'h0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b001);
        chk("fwd_pend_taken", 3'(obs_bt0), 3'b001);

        // Stall blocks capture; flush squashes EX but the pending ADD commits
        step(1'b1, 4'h0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000);
        #1; chk("stall_no_commit", fw1, 3'b000);
        step(1'b1, 4'h0, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000);
        step(1'b1, 4'h1, 3'b110, 1'b0, 1'b1, 1'b0, 3'b000);
        chk("flush_pending_commits", obs_we1, 3'b111);
        #1; chk("flush_no_commit", fw1, 3'b000);
        step(1'b1, 4'h1, 3'b110, 1'b1, 1'b1, 1'b0, 3'b000);
        #1; chk("stall_flush_bubble", fw1, 3'b000);

        // Halt: preceding SUB commits, then unit freezes until reset
        step(1'b1, 4'h1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000);
        step(1'b1, 4'hF, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("halt_sub_commits", obs_we1, 3'b111);
        #1; chk("halted_set", 3'(h1), 3'b001); chk("hlt_no_we", fw1, 3'b000);
        step(1'b1, 4'h0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000);
        #1; chk("halted_add_no_we", fw1, 3'b000);
        idle();
        do_reset();
        idle();

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            if ((m_halt && ($urandom % 4 == 0)) || ($urandom % 80 == 0)) begin
                do_reset();
            end
            step(($urandom % 4) != 0, 4'($urandom), 3'($urandom),
                 ($urandom % 5) == 0, ($urandom % 6) == 0,
                 ($urandom % 2) == 0, 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
